// File: rtl/hsync_module.sv
// Horizontal timing generator: walks each scan line through SYNC, BACK, ACTIVE
// and FRONT segments on pixel ticks, decoding hsync, HActive, xposition and LineEnd.
module hsync_module #(
    parameter logic HSYNC_ACTIVE_LEVEL = 1'b0,
    parameter int   CNT_W              = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             PixelTick,
    input  logic [CNT_W-1:0] SynchPulse,
    input  logic [CNT_W-1:0] BackPorch,
    input  logic [CNT_W-1:0] ActiveVideo,
    input  logic [CNT_W-1:0] FrontPorch,
    output logic             hsync,
    output logic             HActive,
    output logic [CNT_W-1:0] xposition,
    output logic             LineEnd
);

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_BACK   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_FRONT  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [CNT_W-1:0] seg_len;
    logic [CNT_W-1:0] seg_last;
    logic             seg_done;

    // Live length of the segment being walked; a zero length behaves as one tick.
    always_comb begin
        seg_len = SynchPulse;
        case (state_q)
            ST_SYNC:   seg_len = SynchPulse;
            ST_BACK:   seg_len = BackPorch;
            ST_ACTIVE: seg_len = ActiveVideo;
            ST_FRONT:  seg_len = FrontPorch;
            default:   seg_len = SynchPulse;
        endcase
    end

    assign seg_last = (seg_len == '0) ? '0 : seg_len - CNT_W'(1);
    // >= rather than == so a length shrunk below the count ends the segment at once.
    assign seg_done = (cnt_q >= seg_last);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_SYNC, ST_BACK, ST_ACTIVE, ST_FRONT: begin
                if (PixelTick) begin
                    if (seg_done) begin
                        cnt_d = '0;
                        case (state_q)
                            ST_SYNC:   state_d = ST_BACK;
                            ST_BACK:   state_d = ST_ACTIVE;
                            ST_ACTIVE: state_d = ST_FRONT;
                            default:   state_d = ST_SYNC;
                        endcase
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_SYNC;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_SYNC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hsync     = (state_q == ST_SYNC) ? HSYNC_ACTIVE_LEVEL : ~HSYNC_ACTIVE_LEVEL;
    assign HActive   = (state_q == ST_ACTIVE);
    assign xposition = (state_q == ST_ACTIVE) ? cnt_q : '0;
    // The line leaves FRONT on the same tick, so this cannot stay high a second clock.
    assign LineEnd   = PixelTick & (state_q == ST_FRONT) & seg_done;

endmodule
